hdmux2_burst_arb: RTL and testbench
===================================

Name: hdmux2_burst_arb

Overview:
- Two-requester round-robin burst arbiter that shares one W-bit 2:1 mux datapath and one downstream valid/ready sink.
- Owns the select line (SL) and holds it stable for a whole burst, so the mux output never switches mid-transfer.
- Sits between two producer channels and a single consumer port in the xsim std-cell model harness.

Parameters:
- W, 8, data width of each channel and of Z.
- LW, 4, width of the burst-length fields; bursts are 1 to 2^LW beats.

Ports:
- CK  input  1  clock; all state updates on the rising edge.
- RST  input  1  reset; synchronous, active-high.
- REQ0  input  1  channel 0 burst request; held high until the burst completes.
- LEN0  input  LW  channel 0 burst length minus 1; sampled at grant.
- D0  input  W  channel 0 beat data.
- V0  input  1  channel 0 beat valid.
- RDY0  output  1  channel 0 beat accepted.
- REQ1, LEN1, D1, V1, RDY1: same as channel 0, for channel 1.
- Z  output  W  muxed data to the sink.
- ZV  output  1  Z valid.
- ZRDY  input  1  sink ready.
- SL  output  1  mux select: 0 selects D0, 1 selects D1.
- GNT0, GNT1  output  1  one-hot grant; both low when idle.
- ABORT  output  1  one-cycle pulse when the granted requester drops REQ mid-burst.

Behaviour:
- Reset (RST high at an edge):
  - State goes to IDLE.
  - GNT0 = GNT1 = 0, SL = 0, ABORT = 0.
  - Beat counter CNT = 0.
  - Last-served pointer LAST = 1, so channel 0 wins the first tie.
  - Reset overrides everything, including an in-flight burst; no beat is accepted in the reset cycle.
- States: IDLE, G0, G1. GNTx = (state == Gx), registered.
- IDLE:
  - If only REQx is high, go to Gx.
  - If both are high, grant the channel that is not LAST.
  - On entry to Gx, CNT is loaded with LENx and SL is set to x.
  - With no request, stay in IDLE; SL holds its last value (no toggle while idle).
  - Grant latency: REQ rising to GNT high is 1 cycle.
- Combinational datapath:
  - Z = SL ? D1 : D0.
  - ZV = (G0 & V0) | (G1 & V1).
  - RDYx = GNTx & ZRDY.
  - A beat transfers in any cycle where ZV & ZRDY is high.
- Gx, beat transfer with CNT > 0: CNT decrements by 1.
- Gx, beat transfer with CNT == 0 (last beat):
  - LAST is set to x.
  - If the other channel's REQ is high, go directly to G(other), load CNT with LEN(other) and flip SL. There is no idle bubble on handoff.
  - Otherwise go to IDLE.
  - REQx may drop in the same cycle as the last beat; this is legal.
- Gx with ZV low or ZRDY low: hold state, CNT and SL.
- Gx, REQx low before the last beat:
  - Go to IDLE at the next edge and pulse ABORT high for exactly 1 cycle.
  - Set LAST to x.
  - Beats already transferred are not rolled back.
  - A transfer coinciding with the drop is still accepted, because RDYx is combinational on GNTx.
- LENx changes after grant are ignored. CNT is never observable outside the block and never wraps below 0.
- GNT0 and GNT1 are never both high. SL changes only on a grant edge.

Decomposition:
- Shared package hdmux2_arb_pkg:
  - state enum {IDLE, G0, G1}.
  - Channel index constants CH0 = 0 and CH1 = 1.
  - Default W and LW.
- One sub-module, hdmux2_wide: W-bit 2:1 data mux (A0, A1, SL -> Z).
  - Same select semantics as the library mux cell, bit-replicated.
  - The arbiter instantiates it for Z.

Test Plan:
- Reset release, REQ0 = 1, LEN0 = 2, V0 = 1, ZRDY = 1 → GNT0 high 1 cycle after REQ0; Z = D0 for exactly 3 beats; return to IDLE; SL stays 0.
- REQ0 and REQ1 rise in the same cycle with LEN = 0 each → G0 first (1 beat), then direct handoff to G1 with SL 0→1 on the next edge, no idle cycle; then IDLE.
- Repeat the tie after the previous scenario → channel 0 granted next, confirming LAST alternation.
- G1, LEN1 = 3, ZRDY toggling 1,0,0,1,1,1 → exactly 4 transfers; CNT holds on the stall cycles; GNT1 drops after the 4th transfer; SL remains 1 throughout.
- G0, LEN0 = 7, REQ0 dropped after 2 beats → ABORT high 1 cycle, IDLE next edge, GNT0 = 0; a pending REQ1 is granted the cycle after.
- RST asserted mid-burst in G1 → next edge GNT0 = GNT1 = 0, SL = 0, ABORT = 0, RDY1 = 0; after release, a tie grants channel 0 (LAST reset to 1).

Source files
------------

// File: rtl/hdmux2_arb_pkg.sv
// hdmux2_arb_pkg
// Shared definitions for the two-channel burst arbiter and its wide mux.
// Holds the arbiter state encoding, the channel index constants that
// double as select-line values, and the default data/length widths.
package hdmux2_arb_pkg;

  // Default data width of each channel and of the muxed output
  localparam int W_DEF  = 8;
  // Default width of the burst-length fields (bursts of 1..2^LW beats)
  localparam int LW_DEF = 4;

  // Channel indices; these are also the select-line encodings of the mux
  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;

  // Arbiter states: idle, or a burst owned by channel 0 or channel 1
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_e;

endpackage

// File: rtl/hdmux2_burst_arb_if.sv
// hdmux2_burst_arb_if
// Bundles the two producer channels, the consumer port and the arbiter
// status outputs of hdmux2_burst_arb.
//   master : the arbiter side (drives RDYx, Z, ZV, SL, GNTx, ABORT)
//   slave  : the environment side (drives REQx, LENx, Dx, Vx, ZRDY)
// Signals:
//   REQx/LENx/Dx/Vx/RDYx  channel x request, length-1, data, valid, accept
//   Z/ZV/ZRDY             muxed data, valid, sink ready
//   SL                    mux select (0 -> D0, 1 -> D1)
//   GNT0/GNT1             one-hot registered grant
//   ABORT                 one-cycle pulse on a mid-burst request drop
interface hdmux2_burst_arb_if #(
  parameter int W  = hdmux2_arb_pkg::W_DEF,
  parameter int LW = hdmux2_arb_pkg::LW_DEF
);

  logic          REQ0;
  logic [LW-1:0] LEN0;
  logic [W-1:0]  D0;
  logic          V0;
  logic          RDY0;

  logic          REQ1;
  logic [LW-1:0] LEN1;
  logic [W-1:0]  D1;
  logic          V1;
  logic          RDY1;

  logic [W-1:0]  Z;
  logic          ZV;
  logic          ZRDY;

  logic          SL;
  logic          GNT0;
  logic          GNT1;
  logic          ABORT;

  modport master (
    input  REQ0, LEN0, D0, V0,
    input  REQ1, LEN1, D1, V1,
    input  ZRDY,
    output RDY0, RDY1, Z, ZV, SL, GNT0, GNT1, ABORT
  );

  modport slave (
    output REQ0, LEN0, D0, V0,
    output REQ1, LEN1, D1, V1,
    output ZRDY,
    input  RDY0, RDY1, Z, ZV, SL, GNT0, GNT1, ABORT
  );

endinterface

// File: rtl/hdmux2_wide.sv
// hdmux2_wide
// W-bit 2:1 data mux, the library mux cell replicated per bit.
// Ports:
//   A0 : data selected when SL = 0
//   A1 : data selected when SL = 1
//   SL : select
//   Z  : muxed output
module hdmux2_wide #(
  parameter int W = hdmux2_arb_pkg::W_DEF
) (
  input  logic [W-1:0] A0,
  input  logic [W-1:0] A1,
  input  logic         SL,
  output logic [W-1:0] Z
);

  // Every bit shares the one select line, so all bits switch together
  assign Z = SL ? A1 : A0;

endmodule

// File: rtl/hdmux2_burst_arb.sv
// hdmux2_burst_arb
// Two-requester round-robin burst arbiter in front of a shared W-bit 2:1
// mux and one valid/ready sink. The select line is owned by the arbiter
// and only moves on a grant edge, so the mux never switches mid-burst.
// Ports:
//   CK  : clock, all state updates on the rising edge
//   RST : synchronous active-high reset
//   bus : channel, sink and status signals (see hdmux2_burst_arb_if)
module hdmux2_burst_arb
  import hdmux2_arb_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int LW = LW_DEF
) (
  input  logic                CK,
  input  logic                RST,
  hdmux2_burst_arb_if.master  bus
);

  state_e        state_q, state_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic          sl_q, sl_d;
  logic          last_q, last_d;
  logic          abort_q, abort_d;

  logic gnt0;
  logic gnt1;
  logic xfer;

  assign gnt0 = (state_q == G0);
  assign gnt1 = (state_q == G1);

  // Handshake is combinational on the registered grant; it is forced low
  // while RST is high so that a reset cycle never accepts a beat.
  assign bus.ZV   = ~RST & ((gnt0 & bus.V0) | (gnt1 & bus.V1));
  assign bus.RDY0 = ~RST & gnt0 & bus.ZRDY;
  assign bus.RDY1 = ~RST & gnt1 & bus.ZRDY;
  assign xfer     = bus.ZV & bus.ZRDY;

  assign bus.SL    = sl_q;
  assign bus.GNT0  = gnt0;
  assign bus.GNT1  = gnt1;
  assign bus.ABORT = abort_q;

  hdmux2_wide #(.W(W)) uMux (
    .A0 (bus.D0),
    .A1 (bus.D1),
    .SL (sl_q),
    .Z  (bus.Z)
  );

  // Next-state logic. In IDLE a tie goes to the channel that was not
  // served last. Inside a burst, a last-beat transfer takes priority over
  // a request drop (dropping REQ on the last beat is a normal finish);
  // completion hands straight to a waiting peer with no idle bubble.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sl_d    = sl_q;
    last_d  = last_q;
    abort_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.REQ0 && (!bus.REQ1 || last_q == CH1)) begin
          state_d = G0;
          cnt_d   = bus.LEN0;
          sl_d    = CH0;
        end else if (bus.REQ1) begin
          state_d = G1;
          cnt_d   = bus.LEN1;
          sl_d    = CH1;
        end
      end
      G0: begin
        if (xfer && cnt_q == '0) begin
          last_d = CH0;
          if (bus.REQ1) begin
            state_d = G1;
            cnt_d   = bus.LEN1;
            sl_d    = CH1;
          end else begin
            state_d = IDLE;
          end
        end else if (!bus.REQ0) begin
          state_d = IDLE;
          last_d  = CH0;
          abort_d = 1'b1;
        end else if (xfer) begin
          cnt_d = cnt_q - LW'(1);
        end
      end
      G1: begin
        if (xfer && cnt_q == '0) begin
          last_d = CH1;
          if (bus.REQ0) begin
            state_d = G0;
            cnt_d   = bus.LEN0;
            sl_d    = CH0;
          end else begin
            state_d = IDLE;
          end
        end else if (!bus.REQ1) begin
          state_d = IDLE;
          last_d  = CH1;
          abort_d = 1'b1;
        end else if (xfer) begin
          cnt_d = cnt_q - LW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers. LAST resets to channel 1 so channel 0 wins the
  // first tie after reset; SL resets to channel 0.
  always_ff @(posedge CK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sl_q    <= CH0;
      last_q  <= CH1;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sl_q    <= sl_d;
      last_q  <= last_d;
      abort_q <= abort_d;
    end
  end

endmodule

// File: tb/tb_hdmux2_burst_arb.sv
// tb_hdmux2_burst_arb
// Directed bench for hdmux2_burst_arb. Stimulus pushes the beats it
// expects into a scoreboard queue; a monitor pops one entry per sink
// transfer and compares data, select and the owning channel's ready.
// Grant, select and abort timing is checked directly by the stimulus.
module tb_hdmux2_burst_arb;

  typedef struct packed {
    logic       ch;
    logic [7:0] data;
  } beat_t;

  logic CK;
  logic RST;

  hdmux2_burst_arb_if #(.W(8), .LW(4)) bus ();

  hdmux2_burst_arb #(.W(8), .LW(4)) dut (
    .CK  (CK),
    .RST (RST),
    .bus (bus)
  );

  beat_t expQ[$];
  beat_t expBeat;
  int    total = 0;
  int    bad   = 0;

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    CK = 1'b0;
    forever #5 CK = ~CK;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic r0, input logic [3:0] l0,
                               input logic [7:0] d0, input logic v0,
                               input logic r1, input logic [3:0] l1,
                               input logic [7:0] d1, input logic v1,
                               input logic zrdy);
    bus.REQ0 = r0; bus.LEN0 = l0; bus.D0 = d0; bus.V0 = v0;
    bus.REQ1 = r1; bus.LEN1 = l1; bus.D1 = d1; bus.V1 = v1;
    bus.ZRDY = zrdy;
  endtask

  task automatic pushBeats(input logic ch, input logic [7:0] data, input int n);
    beat_t b;
    b.ch   = ch;
    b.data = data;
    for (int i = 0; i < n; i++) expQ.push_back(b);
  endtask

  // Advance n rising edges and settle 1 time unit past the last one
  task automatic tick(input int n);
    repeat (n) @(posedge CK);
    #1;
  endtask

  // Monitor: every sink transfer must match the next expected beat
  always @(negedge CK) begin
    if (bus.ZV && bus.ZRDY) begin
      if (expQ.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpectedBeat: got Z=%0h SL=%0b expected no transfer at %0t",
                 bus.Z, bus.SL, $time);
      end else begin
        expBeat = expQ.pop_front();
        checkOutput("beatZ", 32'(bus.Z), 32'(expBeat.data));
        checkOutput("beatSl", 32'(bus.SL), 32'(expBeat.ch));
        checkOutput("beatRdy", 32'(expBeat.ch ? bus.RDY1 : bus.RDY0), 32'd1);
      end
    end
  end

  initial begin
    RST = 1'b1;
    applyStimulus(0, 4'd0, 8'h00, 0, 0, 4'd0, 8'h00, 0, 0);
    tick(2);
    checkOutput("rstGnt0", 32'(bus.GNT0), 32'd0);
    checkOutput("rstGnt1", 32'(bus.GNT1), 32'd0);
    checkOutput("rstSl", 32'(bus.SL), 32'd0);
    checkOutput("rstAbort", 32'(bus.ABORT), 32'd0);
    RST = 1'b0;

    // Single channel 0 burst of 3 beats
    applyStimulus(1, 4'd2, 8'h11, 1, 0, 4'd0, 8'h00, 0, 1);
    pushBeats(1'b0, 8'h11, 3);
    tick(1);
    checkOutput("s1Gnt0", 32'(bus.GNT0), 32'd1);
    checkOutput("s1Sl", 32'(bus.SL), 32'd0);
    tick(2);
    bus.REQ0 = 1'b0;
    tick(1);
    checkOutput("s1Idle", 32'(bus.GNT0), 32'd0);
    checkOutput("s1SlHeld", 32'(bus.SL), 32'd0);
    checkOutput("s1Abort", 32'(bus.ABORT), 32'd0);
    checkOutput("s1Beats", 32'(expQ.size()), 32'd0);

    // Fresh reset, then two back-to-back ties to show LAST alternating
    RST = 1'b1;
    tick(2);
    RST = 1'b0;
    for (int rep = 0; rep < 2; rep++) begin
      applyStimulus(1, 4'd0, 8'h22 + 8'(rep * 34), 1, 1, 4'd0, 8'h33 + 8'(rep * 34), 1, 1);
      pushBeats(1'b0, 8'h22 + 8'(rep * 34), 1);
      pushBeats(1'b1, 8'h33 + 8'(rep * 34), 1);
      tick(1);
      checkOutput("tieGnt0", 32'(bus.GNT0), 32'd1);
      checkOutput("tieSl0", 32'(bus.SL), 32'd0);
      bus.REQ0 = 1'b0;
      tick(1);
      checkOutput("handoffGnt1", 32'(bus.GNT1), 32'd1);
      checkOutput("handoffGnt0", 32'(bus.GNT0), 32'd0);
      checkOutput("handoffSl", 32'(bus.SL), 32'd1);
      bus.REQ1 = 1'b0;
      tick(1);
      checkOutput("tieIdle", 32'(bus.GNT1), 32'd0);
      checkOutput("tieBeats", 32'(expQ.size()), 32'd0);
    end

    // Channel 1 burst of 4 with ZRDY stalls and a late LEN1 change
    applyStimulus(0, 4'd0, 8'h00, 0, 1, 4'd3, 8'h66, 1, 1);
    pushBeats(1'b1, 8'h66, 4);
    tick(1);
    checkOutput("stallGnt1a", 32'(bus.GNT1), 32'd1);
    tick(1);
    bus.ZRDY = 1'b0;
    bus.LEN1 = 4'd0;
    checkOutput("stallGnt1b", 32'(bus.GNT1), 32'd1);
    tick(1);
    checkOutput("stallGnt1c", 32'(bus.GNT1), 32'd1);
    tick(1);
    bus.ZRDY = 1'b1;
    checkOutput("stallGnt1d", 32'(bus.GNT1), 32'd1);
    tick(1);
    checkOutput("stallGnt1e", 32'(bus.GNT1), 32'd1);
    checkOutput("stallSl", 32'(bus.SL), 32'd1);
    tick(1);
    checkOutput("stallGnt1f", 32'(bus.GNT1), 32'd1);
    bus.REQ1 = 1'b0;
    tick(1);
    checkOutput("stallDone", 32'(bus.GNT1), 32'd0);
    checkOutput("stallSlHeld", 32'(bus.SL), 32'd1);
    checkOutput("stallBeats", 32'(expQ.size()), 32'd0);

    // Channel 0 aborts mid-burst with channel 1 pending; the beat in the
    // drop cycle still transfers
    applyStimulus(1, 4'd7, 8'h77, 1, 1, 4'd0, 8'h88, 1, 1);
    pushBeats(1'b0, 8'h77, 3);
    pushBeats(1'b1, 8'h88, 1);
    tick(1);
    checkOutput("abGnt0", 32'(bus.GNT0), 32'd1);
    tick(2);
    bus.REQ0 = 1'b0;
    checkOutput("abNoPulseYet", 32'(bus.ABORT), 32'd0);
    tick(1);
    checkOutput("abPulse", 32'(bus.ABORT), 32'd1);
    checkOutput("abGnt0Low", 32'(bus.GNT0), 32'd0);
    checkOutput("abGnt1Low", 32'(bus.GNT1), 32'd0);
    tick(1);
    checkOutput("abPulseEnd", 32'(bus.ABORT), 32'd0);
    checkOutput("abGnt1", 32'(bus.GNT1), 32'd1);
    checkOutput("abSl", 32'(bus.SL), 32'd1);
    bus.REQ1 = 1'b0;
    tick(1);
    checkOutput("abDone", 32'(bus.GNT1), 32'd0);
    checkOutput("abBeats", 32'(expQ.size()), 32'd0);

    // Reset in the middle of a channel 1 burst, then a tie goes to channel 0
    applyStimulus(0, 4'd0, 8'h00, 0, 1, 4'd5, 8'h99, 1, 1);
    pushBeats(1'b1, 8'h99, 1);
    tick(1);
    checkOutput("rmGnt1", 32'(bus.GNT1), 32'd1);
    tick(1);
    RST = 1'b1;
    tick(1);
    checkOutput("rmGnt0", 32'(bus.GNT0), 32'd0);
    checkOutput("rmGnt1Low", 32'(bus.GNT1), 32'd0);
    checkOutput("rmSl", 32'(bus.SL), 32'd0);
    checkOutput("rmAbort", 32'(bus.ABORT), 32'd0);
    checkOutput("rmRdy1", 32'(bus.RDY1), 32'd0);
    RST = 1'b0;
    applyStimulus(1, 4'd0, 8'hAA, 1, 1, 4'd0, 8'hBB, 1, 1);
    pushBeats(1'b0, 8'hAA, 1);
    pushBeats(1'b1, 8'hBB, 1);
    tick(1);
    checkOutput("rmTieGnt0", 32'(bus.GNT0), 32'd1);
    checkOutput("rmTieSl", 32'(bus.SL), 32'd0);
    bus.REQ0 = 1'b0;
    tick(1);
    checkOutput("rmHandoff", 32'(bus.GNT1), 32'd1);
    checkOutput("rmHandoffSl", 32'(bus.SL), 32'd1);
    bus.REQ1 = 1'b0;
    tick(1);
    checkOutput("rmIdle", 32'(bus.GNT1), 32'd0);
    checkOutput("rmBeats", 32'(expQ.size()), 32'd0);

    tick(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
